mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 64 ++++++
 rtl/mc_controller_outdec.sv | 89 ++++++++
 rtl/mc_controller.sv | 80 ++++++++
 tb/tb_mc_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// ALU/mux select codes and the bundled control word.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ORIEX, S_ANDIEX, S_IMMWB, S_JEX
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic       pcen;
    logic       illegal_op;
    logic [2:0] aluop;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
  } ctrl_t;

  // DECODE dispatch; an unrecognised opcode maps back to FETCH.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = S_RTYPEEX;
      OP_BEQ:       decode_target = S_BEQEX;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_ORI:       decode_target = S_ORIEX;
      OP_ANDI:      decode_target = S_ANDIEX;
      OP_J:         decode_target = S_JEX;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_outdec.sv
// Control-word decoder: maps the current state (plus the few live flags)
// to datapath controls; write strobes are suppressed while reset is held.
module mc_outdec
  import mc_controller_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op,
  input  logic       i_jr,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  input  logic       i_reset,
  output ctrl_t      o_ctrl
);

  ctrl_t w_dec;

  always_comb begin
    w_dec         = '0;
    w_dec.aluop   = ALUOP_ADD;
    w_dec.alusrcb = SRCB_REGB;
    w_dec.pcsrc   = PCSRC_ALU;
    case (i_state)
      S_FETCH: begin
        w_dec.alusrcb = SRCB_FOUR;
        w_dec.irwrite = i_mem_ready;
        w_dec.pcen    = i_mem_ready;
      end
      S_DECODE: begin
        w_dec.alusrcb    = SRCB_IMMSH;
        w_dec.illegal_op = (decode_target(i_op) == S_FETCH);
      end
      S_MEMADR: begin
        w_dec.alusrca = 1'b1;
        w_dec.alusrcb = SRCB_IMM;
      end
      S_MEMRD: w_dec.iord = 1'b1;
      S_MEMWB: begin
        w_dec.regwrite = 1'b1;
        w_dec.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_dec.iord     = 1'b1;
        w_dec.memwrite = i_mem_ready;
      end
      S_RTYPEEX: begin
        w_dec.alusrca = 1'b1;
        w_dec.aluop   = ALUOP_FUNCT;
        if (i_jr) begin
          w_dec.pcen  = 1'b1;
          w_dec.pcsrc = PCSRC_REG;
        end
      end
      S_RTYPEWB: begin
        w_dec.regwrite = 1'b1;
        w_dec.regdst   = 1'b1;
      end
      S_BEQEX: begin
        w_dec.alusrca = 1'b1;
        w_dec.aluop   = ALUOP_SUB;
        w_dec.pcsrc   = PCSRC_ALUOUT;
        w_dec.pcen    = i_zero;
      end
      S_ADDIEX, S_ORIEX, S_ANDIEX: begin
        w_dec.alusrca = 1'b1;
        w_dec.alusrcb = SRCB_IMM;
        w_dec.aluop   = (i_state == S_ORIEX)  ? ALUOP_OR :
                        (i_state == S_ANDIEX) ? ALUOP_AND : ALUOP_ADD;
      end
      S_IMMWB: w_dec.regwrite = 1'b1;
      S_JEX: begin
        w_dec.pcsrc = PCSRC_JUMP;
        w_dec.pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ctrl = w_dec;
    if (i_reset) begin
      o_ctrl.irwrite    = 1'b0;
      o_ctrl.pcen       = 1'b0;
      o_ctrl.regwrite   = 1'b0;
      o_ctrl.memwrite   = 1'b0;
      o_ctrl.illegal_op = 1'b0;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register and next-state logic,
// with the control outputs produced by the mc_outdec decoder.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       jr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] aluop,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic       pcen,
  output logic       illegal_op,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] state_o
);

  state_t r_state;
  state_t w_next;
  logic   w_rdy;
  ctrl_t  w_ctrl;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (w_rdy) w_next = S_DECODE;
      S_DECODE:  w_next = decode_target(op);
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (w_rdy) w_next = S_MEMWB;
      S_MEMWR:   if (w_rdy) w_next = S_FETCH;
      S_RTYPEEX: w_next = jr ? S_FETCH : S_RTYPEWB;
      S_ADDIEX, S_ORIEX, S_ANDIEX: w_next = S_IMMWB;
      default:   w_next = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_op        (op),
    .i_jr        (jr),
    .i_zero      (zero),
    .i_mem_ready (w_rdy),
    .i_reset     (reset),
    .o_ctrl      (w_ctrl)
  );

  assign aluop      = w_ctrl.aluop;
  assign irwrite    = w_ctrl.irwrite;
  assign regwrite   = w_ctrl.regwrite;
  assign memwrite   = w_ctrl.memwrite;
  assign iord       = w_ctrl.iord;
  assign memtoreg   = w_ctrl.memtoreg;
  assign regdst     = w_ctrl.regdst;
  assign alusrca    = w_ctrl.alusrca;
  assign pcen       = w_ctrl.pcen;
  assign illegal_op = w_ctrl.illegal_op;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle vector table through a
// scoreboard queue, plus hand-written reset sequences.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic       clk, reset, jr, zero, mem_ready;
  logic [5:0] op;
  logic [2:0] aluop;
  logic       irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] state_o;

  mc_controller #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .op(op), .jr(jr), .zero(zero), .mem_ready(mem_ready),
    .aluop(aluop), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .pcen(pcen), .illegal_op(illegal_op), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, pcen, illegal_op}
  typedef struct {
    logic [5:0] op;
    logic       jr, zero, rdy;
    state_t     st;
    logic [2:0] aluop;
    logic [1:0] srcb, pcsrc;
    logic [8:0] flags;
  } vec_t;

  localparam logic [8:0] F_NONE  = 9'b000000000;
  localparam logic [8:0] F_FETCH = 9'b100000010;
  localparam logic [8:0] F_SRCA  = 9'b000000100;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t V(input logic [5:0] o, input logic j, input logic z, input logic r,
                             input state_t s, input logic [2:0] a, input logic [1:0] b,
                             input logic [1:0] p, input logic [8:0] f);
    vec_t v;
    v.op = o; v.jr = j; v.zero = z; v.rdy = r; v.st = s;
    v.aluop = a; v.srcb = b; v.pcsrc = p; v.flags = f;
    return v;
  endfunction

  task automatic add_fd(input logic [5:0] o, input logic j, input logic z);
    vecs.push_back(V(o, j, z, 1'b1, S_FETCH,  3'b000, 2'b01, 2'b00, F_FETCH));
    vecs.push_back(V(o, j, z, 1'b1, S_DECODE, 3'b000, 2'b11, 2'b00, F_NONE));
  endtask

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [8:0] flags_now();
    return {irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, pcen, illegal_op};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    op = v.op; jr = v.jr; zero = v.zero; mem_ready = v.rdy;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", idx, {12'd0, state_o}, {12'd0, e.st});
    check("aluop", idx, {13'd0, aluop},   {13'd0, e.aluop});
    check("srcb",  idx, {14'd0, alusrcb}, {14'd0, e.srcb});
    check("pcsrc", idx, {14'd0, pcsrc},   {14'd0, e.pcsrc});
    check("flags", idx, {7'd0, flags_now()}, {7'd0, e.flags});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // lw, sw
    add_fd(OP_LW, 1'b0, 1'b0);
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMADR, 3'b000, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMRD,  3'b000, 2'b00, 2'b00, 9'b000100000));
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMWB,  3'b000, 2'b00, 2'b00, 9'b010010000));
    add_fd(OP_SW, 1'b0, 1'b0);
    vecs.push_back(V(OP_SW, 1'b0, 1'b0, 1'b1, S_MEMADR, 3'b000, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_SW, 1'b0, 1'b0, 1'b1, S_MEMWR,  3'b000, 2'b00, 2'b00, 9'b001100000));
    // R-type, jr
    add_fd(OP_RTYPE, 1'b0, 1'b0);
    vecs.push_back(V(OP_RTYPE, 1'b0, 1'b0, 1'b1, S_RTYPEEX, 3'b010, 2'b00, 2'b00, F_SRCA));
    vecs.push_back(V(OP_RTYPE, 1'b0, 1'b0, 1'b1, S_RTYPEWB, 3'b000, 2'b00, 2'b00, 9'b010001000));
    add_fd(OP_RTYPE, 1'b1, 1'b0);
    vecs.push_back(V(OP_RTYPE, 1'b1, 1'b0, 1'b1, S_RTYPEEX, 3'b010, 2'b00, 2'b11, 9'b000000110));
    // beq taken / not taken
    add_fd(OP_BEQ, 1'b0, 1'b1);
    vecs.push_back(V(OP_BEQ, 1'b0, 1'b1, 1'b1, S_BEQEX, 3'b001, 2'b00, 2'b01, 9'b000000110));
    add_fd(OP_BEQ, 1'b0, 1'b0);
    vecs.push_back(V(OP_BEQ, 1'b0, 1'b0, 1'b1, S_BEQEX, 3'b001, 2'b00, 2'b01, F_SRCA));
    // immediates
    add_fd(OP_ADDI, 1'b0, 1'b0);
    vecs.push_back(V(OP_ADDI, 1'b0, 1'b0, 1'b1, S_ADDIEX, 3'b000, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_ADDI, 1'b0, 1'b0, 1'b1, S_IMMWB,  3'b000, 2'b00, 2'b00, 9'b010000000));
    add_fd(OP_ORI, 1'b0, 1'b0);
    vecs.push_back(V(OP_ORI, 1'b0, 1'b0, 1'b1, S_ORIEX, 3'b011, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_ORI, 1'b0, 1'b0, 1'b1, S_IMMWB, 3'b000, 2'b00, 2'b00, 9'b010000000));
    add_fd(OP_ANDI, 1'b0, 1'b0);
    vecs.push_back(V(OP_ANDI, 1'b0, 1'b0, 1'b1, S_ANDIEX, 3'b100, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_ANDI, 1'b0, 1'b0, 1'b1, S_IMMWB,  3'b000, 2'b00, 2'b00, 9'b010000000));
    // jump
    add_fd(OP_J, 1'b0, 1'b0);
    vecs.push_back(V(OP_J, 1'b0, 1'b0, 1'b1, S_JEX, 3'b000, 2'b00, 2'b10, 9'b000000010));
    // illegal opcode: FETCH, DECODE(illegal), FETCH
    vecs.push_back(V(6'b111111, 1'b0, 1'b0, 1'b1, S_FETCH,  3'b000, 2'b01, 2'b00, F_FETCH));
    vecs.push_back(V(6'b111111, 1'b0, 1'b0, 1'b1, S_DECODE, 3'b000, 2'b11, 2'b00, 9'b000000001));
    // fetch stall for two cycles, then j
    vecs.push_back(V(OP_J, 1'b0, 1'b0, 1'b0, S_FETCH, 3'b000, 2'b01, 2'b00, F_NONE));
    vecs.push_back(V(OP_J, 1'b0, 1'b0, 1'b0, S_FETCH, 3'b000, 2'b01, 2'b00, F_NONE));
    add_fd(OP_J, 1'b0, 1'b0);
    vecs.push_back(V(OP_J, 1'b0, 1'b0, 1'b1, S_JEX, 3'b000, 2'b00, 2'b10, 9'b000000010));
    // sw with three memory wait cycles: 7 cycles total
    add_fd(OP_SW, 1'b0, 1'b0);
    vecs.push_back(V(OP_SW, 1'b0, 1'b0, 1'b1, S_MEMADR, 3'b000, 2'b10, 2'b00, F_SRCA));
    for (int i = 0; i < 3; i++)
      vecs.push_back(V(OP_SW, 1'b0, 1'b0, 1'b0, S_MEMWR, 3'b000, 2'b00, 2'b00, 9'b000100000));
    vecs.push_back(V(OP_SW, 1'b0, 1'b0, 1'b1, S_MEMWR, 3'b000, 2'b00, 2'b00, 9'b001100000));
    // lw with one read wait cycle
    add_fd(OP_LW, 1'b0, 1'b0);
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMADR, 3'b000, 2'b10, 2'b00, F_SRCA));
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b0, S_MEMRD,  3'b000, 2'b00, 2'b00, 9'b000100000));
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMRD,  3'b000, 2'b00, 2'b00, 9'b000100000));
    vecs.push_back(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMWB,  3'b000, 2'b00, 2'b00, 9'b010010000));
    vecs.push_back(V(OP_J,  1'b0, 1'b0, 1'b1, S_FETCH,  3'b000, 2'b01, 2'b00, F_FETCH));

    // Reset held across clock edges with mem_ready high: strobes forced low
    reset = 1'b1; op = OP_LW; jr = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 0, {12'd0, state_o}, {12'd0, S_FETCH});
    check("rst_flags", 0, {7'd0, flags_now()}, {7'd0, F_NONE});
    check("rst_srcb",  0, {14'd0, alusrcb}, {14'd0, SRCB_FOUR});
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Asynchronous reset pulse in MEMRD abandons the load
    run_vec(V(OP_LW, 1'b0, 1'b0, 1'b1, S_DECODE, 3'b000, 2'b11, 2'b00, F_NONE), 900);
    run_vec(V(OP_LW, 1'b0, 1'b0, 1'b1, S_MEMADR, 3'b000, 2'b10, 2'b00, F_SRCA), 901);
    op = OP_LW; mem_ready = 1'b1;
    check("pre_rst_state", 902, {12'd0, state_o}, {12'd0, S_MEMRD});
    reset = 1'b1;
    #1;
    check("async_rst_state", 903, {12'd0, state_o}, {12'd0, S_FETCH});
    check("async_rst_flags", 903, {7'd0, flags_now()}, {7'd0, F_NONE});
    #1;
    reset = 1'b0;
    run_vec(V(OP_J, 1'b0, 1'b0, 1'b1, S_FETCH,  3'b000, 2'b01, 2'b00, F_FETCH), 904);
    run_vec(V(OP_J, 1'b0, 1'b0, 1'b1, S_DECODE, 3'b000, 2'b11, 2'b00, F_NONE), 905);
    run_vec(V(OP_J, 1'b0, 1'b0, 1'b1, S_JEX,    3'b000, 2'b00, 2'b10, 9'b000000010), 906);
    run_vec(V(OP_J, 1'b0, 1'b0, 1'b1, S_FETCH,  3'b000, 2'b01, 2'b00, F_FETCH), 907);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
